if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue.sv | 106 ++++++++++
 tb/tb_if_id_queue.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_queue
//  Description : Fetch-to-decode instruction queue. A circular buffer of
//                {inst, pc} entries sits between the fetch stage (push side)
//                and the decode stage (pop side). When the queue is empty,
//                decode is given NOP_INST at PC 0. A flush (redirect) empties
//                the queue at the next edge and drops any push or pop in that
//                cycle.
//
//  Ports       : clk       - clock, all state updates on the rising edge
//                rst       - synchronous active-high reset
//                if_valid  - fetch presents a valid instruction
//                if_inst   - fetched instruction (32 b)
//                if_pc     - PC of if_inst (64 b)
//                if_ready  - queue accepts a push (low = hold fetch)
//                flush     - redirect; discard queued and incoming entries
//                id_ready  - decode consumes the head entry
//                id_valid  - head entry is valid
//                id_inst   - head instruction (NOP_INST when empty)
//                id_pc     - head PC (0 when empty)
//                count     - current occupancy
//
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_valid,
    input  logic [31:0]                if_inst,
    input  logic [63:0]                if_pc,
    output logic                       if_ready,
    input  logic                       flush,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [31:0]                id_inst,
    output logic [63:0]                id_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int                c_ptr_w   = $clog2(DEPTH);
    localparam int                c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    // Entry storage is deliberately left without reset: its content is only
    // observed while the occupancy is non-zero.
    logic [31:0]        r_inst [DEPTH];
    logic [63:0]        r_pc   [DEPTH];

    logic [c_ptr_w-1:0] r_wp;
    logic [c_ptr_w-1:0] r_rp;
    logic [c_cnt_w-1:0] r_count;

    logic w_empty;
    logic w_push;
    logic w_pop;

    // Ready and valid depend only on the registered occupancy, so there is no
    // combinational path from if_valid or id_ready to either handshake.
    // A pop while full therefore does not open the queue until the next cycle.
    assign w_empty  = (r_count == '0);
    assign if_ready = (r_count < c_depth);
    assign id_valid = !w_empty;

    assign w_push = if_valid && if_ready && !flush;
    assign w_pop  = id_valid && id_ready && !flush;

    // No bypass: an empty queue shows the NOP, never the incoming fetch.
    assign id_inst = w_empty ? NOP_INST : r_inst[r_rp];
    assign id_pc   = w_empty ? 64'h0    : r_pc[r_rp];
    assign count   = r_count;

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_inst[r_wp] <= if_inst;
            r_pc[r_wp]   <= if_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + c_ptr_one;
            end
            if (w_pop) begin
                r_rp <= r_rp + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_queue
//  Description : Self-checking bench for if_id_queue (DEPTH = 2). A table of
//                directed vectors is applied one clock each and the outputs
//                are compared after the edge; short hand-written sequences
//                cover the flush-cycle hold and streaming across pointer wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

    localparam logic [31:0] c_nop = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [63:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [63:0] id_pc;
    logic [1:0]  count;

    int checks;
    int errors;

    if_id_queue #(
        .DEPTH    (2),
        .NOP_INST (c_nop)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .if_inst  (if_inst),
        .if_pc    (if_pc),
        .if_ready (if_ready),
        .flush    (flush),
        .id_ready (id_ready),
        .id_valid (id_valid),
        .id_inst  (id_inst),
        .id_pc    (id_pc),
        .count    (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] inst;
        logic [63:0] pc;
        logic        flush;
        logic        rdy;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [63:0] e_pc;
        logic [1:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] in,
                                input logic [63:0] p, input logic f, input logic rd,
                                input logic er, input logic ev, input logic [31:0] ei,
                                input logic [63:0] ep, input logic [1:0] ec);
        vec_t t;
        t.rst = r;  t.vld = v;  t.inst = in; t.pc = p; t.flush = f; t.rdy = rd;
        t.e_ready = er; t.e_valid = ev; t.e_inst = ei; t.e_pc = ep; t.e_cnt = ec;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic er, input logic ev,
                           input logic [31:0] ei, input logic [63:0] ep, input logic [1:0] ec);
        chk({tag, ".if_ready"}, 64'(if_ready), 64'(er));
        chk({tag, ".id_valid"}, 64'(id_valid), 64'(ev));
        chk({tag, ".id_inst"},  64'(id_inst),  64'(ei));
        chk({tag, ".id_pc"},    id_pc,         ep);
        chk({tag, ".count"},    64'(count),    64'(ec));
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] in,
                         input logic [63:0] p, input logic f, input logic rd);
        @(negedge clk);
        rst = r; if_valid = v; if_inst = in; if_pc = p; flush = f; id_ready = rd;
    endtask

    vec_t vecs [15];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0; flush = 1'b0; id_ready = 1'b0;

        //          rst vld inst          pc              fl rdy  rdy vld inst          pc              cnt
        vecs[0]  = mk(1, 0, 32'h0,        64'h0,          0, 0,   1, 0, c_nop,        64'h0,          2'd0);
        vecs[1]  = mk(0, 1, 32'h00100093, 64'h80000000,   0, 0,   1, 1, 32'h00100093, 64'h80000000,   2'd1);
        vecs[2]  = mk(0, 1, 32'h00200113, 64'h80000004,   0, 0,   0, 1, 32'h00100093, 64'h80000000,   2'd2);
        vecs[3]  = mk(0, 1, 32'h00300193, 64'h80000008,   0, 0,   0, 1, 32'h00100093, 64'h80000000,   2'd2);
        vecs[4]  = mk(0, 0, 32'h0,        64'h0,          0, 1,   1, 1, 32'h00200113, 64'h80000004,   2'd1);
        vecs[5]  = mk(0, 0, 32'h0,        64'h0,          0, 1,   1, 0, c_nop,        64'h0,          2'd0);
        vecs[6]  = mk(0, 1, 32'h00000011, 64'h80000010,   0, 0,   1, 1, 32'h00000011, 64'h80000010,   2'd1);
        vecs[7]  = mk(0, 1, 32'h00000022, 64'h80000014,   0, 1,   1, 1, 32'h00000022, 64'h80000014,   2'd1);
        vecs[8]  = mk(0, 1, 32'h00000033, 64'h80000018,   0, 0,   0, 1, 32'h00000022, 64'h80000014,   2'd2);
        vecs[9]  = mk(0, 1, 32'h00000044, 64'h8000001c,   0, 1,   1, 1, 32'h00000033, 64'h80000018,   2'd1);
        vecs[10] = mk(0, 1, 32'h00000055, 64'h80000020,   1, 1,   1, 0, c_nop,        64'h0,          2'd0);
        vecs[11] = mk(0, 1, 32'h00000066, 64'h80000024,   0, 0,   1, 1, 32'h00000066, 64'h80000024,   2'd1);
        vecs[12] = mk(0, 1, 32'h00000077, 64'h80000028,   0, 0,   0, 1, 32'h00000066, 64'h80000024,   2'd2);
        vecs[13] = mk(1, 1, 32'h00000088, 64'h8000002c,   1, 0,   1, 0, c_nop,        64'h0,          2'd0);
        vecs[14] = mk(0, 0, 32'h0,        64'h0,          0, 0,   1, 0, c_nop,        64'h0,          2'd0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].inst, vecs[i].pc, vecs[i].flush, vecs[i].rdy);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_valid,
                    vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_cnt);
        end

        // No bypass: incoming fetch is not visible before the edge.
        drive(0, 1, 32'h000000a1, 64'h80000100, 0, 0);
        #1;
        chk("bypass.id_valid", 64'(id_valid), 64'd0);
        chk("bypass.id_inst",  64'(id_inst),  64'(c_nop));
        @(posedge clk);
        drive(0, 1, 32'h000000a2, 64'h80000104, 0, 0);
        @(posedge clk);
        #1;
        chk_all("fill", 1'b0, 1'b1, 32'h000000a1, 64'h80000100, 2'd2);

        // Outputs hold through the flush cycle and clear only at the edge.
        drive(0, 1, 32'h000000a3, 64'h80000108, 1, 1);
        #1;
        chk_all("flush_hold", 1'b0, 1'b1, 32'h000000a1, 64'h80000100, 2'd2);
        @(posedge clk);
        #1;
        chk_all("flush_done", 1'b1, 1'b0, c_nop, 64'h0, 2'd0);

        // Streaming 10 sequential PCs with decode always ready; wraps pointers.
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 32'h00000100 + 32'(k), 64'h80000000 + 64'(4 * k), 0, 1);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d.id_pc", k), id_pc, 64'h80000000 + 64'(4 * k));
            chk($sformatf("stream%0d.id_inst", k), 64'(id_inst), 64'(32'h00000100 + 32'(k)));
            chk($sformatf("stream%0d.count", k), 64'(count), 64'd1);
        end
        drive(0, 0, 32'h0, 64'h0, 0, 1);
        @(posedge clk);
        #1;
        chk_all("stream_drain", 1'b1, 1'b0, c_nop, 64'h0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
